// File: rtl/boot_loader.sv
// UART program loader: receives a framed image, writes it into CPU memory,
// and holds the CPU in reset until a frame with a good checksum arrives.
module boot_loader #(
  parameter int          CLK_FREQ     = 27000000,
  parameter int          BAUD         = 115200,
  parameter logic [15:0] LOAD_BASE    = 16'h0000,
  parameter int          TIMEOUT_CLKS = 2700000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          CPB     = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_END = 16'(CPB - 1);
  localparam logic [15:0] HALF_END = 16'(CPB / 2 - 1);
  localparam logic [31:0] TMO     = 32'(TIMEOUT_CLKS);
  localparam logic [7:0]  SYNC    = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    WAIT_SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
  } fr_st_t;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_st_t      rx_st_q, rx_st_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  sh_q, sh_d;
  logic        byte_valid, frame_err;

  fr_st_t      fr_st_q, fr_st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] tmo_q, tmo_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        in_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      bcnt_q    <= '0;
      bidx_q    <= '0;
      sh_q      <= '0;
      fr_st_q   <= WAIT_SYNC;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= LOAD_BASE;
      wdata_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      bcnt_q    <= bcnt_d;
      bidx_q    <= bidx_d;
      sh_q      <= sh_d;
      fr_st_q   <= fr_st_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    bcnt_d  = bcnt_q + 16'd1;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    unique case (rx_st_q)
      RX_IDLE: begin
        bcnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (bcnt_q == HALF_END) begin
          bcnt_d  = '0;
          bidx_d  = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bcnt_q == BIT_END) begin
          bcnt_d = '0;
          sh_d   = {rx_s2_q, sh_q[7:1]};
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bcnt_q == BIT_END) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (rx_st_q == RX_STOP && bcnt_q == BIT_END) begin
      byte_valid = rx_s2_q;
      frame_err  = !rx_s2_q;
    end
  end

  assign in_frame = (fr_st_q == LEN_HI) || (fr_st_q == LEN_LO) ||
                    (fr_st_q == DATA) || (fr_st_q == CSUM);

  always_comb begin
    fr_st_d = fr_st_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    tmo_d   = (!in_frame || byte_valid) ? '0 : tmo_q + 32'd1;
    unique case (fr_st_q)
      WAIT_SYNC, ERR: begin
        if (byte_valid && sh_q == SYNC) begin
          fr_st_d = LEN_HI;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      LEN_HI: begin
        if (byte_valid) begin
          len_d[15:8] = sh_q;
          fr_st_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (byte_valid) begin
          len_d[7:0] = sh_q;
          fr_st_d = ({len_q[15:8], sh_q} != 16'd0) ? DATA : CSUM;
        end
      end
      DATA: begin
        // Leave one cycle after the last byte so its strobe stays inside DATA
        if (byte_valid) begin
          we_d    = 1'b1;
          wdata_d = sh_q;
          addr_d  = LOAD_BASE + idx_q;
          sum_d   = sum_q + sh_q;
          idx_d   = idx_q + 16'd1;
        end else if (idx_q == len_q) begin
          fr_st_d = CSUM;
        end
      end
      CSUM: begin
        if (byte_valid) fr_st_d = (sh_q == sum_q) ? DONE : ERR;
      end
      DONE: ;
      default: fr_st_d = WAIT_SYNC;
    endcase
    if (in_frame && (frame_err || tmo_q >= TMO)) begin
      fr_st_d = ERR;
      we_d    = 1'b0;
    end
  end

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = we_q;
    busy      = in_frame;
    done      = (fr_st_q == DONE);
    err       = (fr_st_q == ERR);
    cpu_hold  = (fr_st_q != DONE);
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- UART program loader upstream of the CPU core.
- Receives a framed program image on a serial line and writes it byte-by-byte into CPU memory through a write port.
- Holds the CPU in reset until a frame with a valid checksum has been loaded, then releases it.
- Also gives a standalone bring-up path for loading code without resynthesising the memory init file.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division).
- LOAD_BASE, 16'h0000, memory address of the first data byte.
- TIMEOUT_CLKS, 2700000, maximum idle clocks between bytes inside a frame before it is aborted.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- rx  input  1  serial input; idles high; 8N1, LSB first.
- mem_addr  output  16  write address to memory.
- mem_wdata  output  8  write data to memory.
- mem_we  output  1  one-cycle write strobe; address and data are valid in the same cycle.
- cpu_hold  output  1  1 = CPU held in reset; drives pc_rst/mem_rst at the top level.
- busy  output  1  1 while a frame is in progress (LEN_HI..CSUM).
- done  output  1  image loaded and checksum good; sticky until reset.
- err  output  1  last frame aborted (checksum, framing or timeout).

Behaviour:
- Reset values: mem_addr=LOAD_BASE, mem_wdata=0, mem_we=0, cpu_hold=1, busy=0, done=0, err=0. Both FSMs go to idle and all counters clear.
- rx passes through a 2-FF synchroniser. The receiver sees rx with 2 cycles of latency.
- Byte receiver FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - RX_IDLE: a synchronised falling edge moves to RX_START.
  - RX_START: sample at CLKS_PER_BIT/2. If high, treat as a glitch and return to RX_IDLE with no error.
  - RX_DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - RX_STOP: sample the stop bit. If 1, raise an internal byte_valid pulse for 1 cycle. If 0, raise frame_err for 1 cycle and discard the byte. Either way, return to RX_IDLE.
- Frame FSM (WAIT_SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR):
  - WAIT_SYNC: bytes other than 8'hA5 are ignored. 8'hA5 moves to LEN_HI; there, clear err and set busy.
  - LEN_HI, LEN_LO: capture the 16-bit length N, big-endian. After LEN_LO, go to DATA if N≠0, otherwise straight to CSUM.
  - DATA: per byte, mem_we=1 for exactly 1 cycle, registered the cycle after byte_valid.
    - Write address is mem_addr = LOAD_BASE + index, computed mod 2^16 (wraps 16'hFFFF→16'h0000).
    - Running sum = (sum + byte) mod 256.
    - After N bytes, go to CSUM.
  - CSUM: the received byte is compared with sum. On a match, go to DONE. On a mismatch, go to ERR.
  - DONE: cpu_hold=0, done=1, busy=0. All further rx traffic is ignored until reset.
  - ERR: err=1, busy=0, cpu_hold stays 1. A new 8'hA5 starts a fresh frame (behaves as WAIT_SYNC).
- frame_err in any state from LEN_HI to CSUM moves to ERR. In WAIT_SYNC, frame_err is ignored.
- Timeout: in states LEN_HI..CSUM, an idle counter resets on each byte_valid. When it reaches TIMEOUT_CLKS, go to ERR. The counter is cleared outside those states.
- Memory writes already made by an aborted frame are not undone.
- mem_we never asserts outside DATA.
- Reset mid-frame: all state returns to reset values immediately; cpu_hold=1.

Test Plan:
Use CLK_FREQ=1600000 and BAUD=100000 (16 clks/bit), LOAD_BASE=16'h0100.
- Frame A5 00 03 11 22 33 66 → mem_we pulses 3 times (0x0100←0x11, 0x0101←0x22, 0x0102←0x33); done=1, cpu_hold=0, err=0.
- Frame A5 00 02 01 02 FF → 2 writes; err=1, cpu_hold=1, done=0. Then send a valid frame A5 00 01 7E 7E → done=1, err=0.
- Leading junk 00 FF 5A, then A5 00 00 00 → no mem_we; done=1 after the checksum byte.
- Stop bit forced 0 on the data byte of A5 00 01 44 → err=1, no mem_we for that byte. A 1/4-bit low glitch on idle rx → no byte, no state change.
- A5 00 04 then silence for TIMEOUT_CLKS+10 cycles → err=1, busy=0.
- LOAD_BASE=16'hFFFF, frame A5 00 02 AA BB 65 → writes 0xFFFF←0xAA, 0x0000←0xBB. Assert rst_n low during a second frame → all outputs return to reset values asynchronously.
